buffer_loader: RTL and testbench
================================

// Module: buffer_loader
// PURPOSE
//   Upstream feeder for the 64-bit scratch buffer. Accepts a byte stream over a
//   valid/ready handshake and packs 8 bytes little-endian into one 64-bit word.
//   Writes each word into the buffer in word mode at auto-incrementing word addresses.
//   Each transfer is a command (start, base word address, byte count); the block
//   reports done when the last word has been written.
// PARAMETERS
//   BuffDepth  128                      buffer size in bytes, multiple of 8
//   ByteAddrW  $clog2(BuffDepth)        byte address width (derived)
//   WordAddrW  $clog2(BuffDepth/8)      word address width (derived)
// PORTS
//   clk           in   1          clock, rising edge
//   rst_n         in   1          asynchronous active-low reset
//   start         in   1          command strobe, sampled in IDLE only
//   base_addr     in   WordAddrW  first buffer word address of the transfer
//   num_bytes     in   ByteAddrW+1 byte count, 0..BuffDepth
//   busy          out  1          high in FILL and WRITE
//   done          out  1          one-cycle pulse at end of a transfer
//   s_valid       in   1          input byte valid
//   s_ready       out  1          loader can accept a byte (high in FILL)
//   s_data        in   8          input byte
//   buf_write_en  out  1          buffer write strobe
//   buf_addr_mode out  1          1 = word access; driven 1 with buf_write_en, else 0
//   buf_word_addr out  WordAddrW  buffer word address
//   buf_word_in   out  64         packed write data
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; all outputs 0; counters, lane index and
//     pack register cleared. A partially packed word is discarded; no write is issued.
//   - FSM (Moore): IDLE, FILL, WRITE, DONE.
//   - IDLE:
//       - start=1 latches base_addr and num_bytes. Go to FILL, or to DONE if num_bytes==0.
//       - s_valid is ignored.
//   - FILL:
//       - s_ready=1. Each handshake (s_valid & s_ready) stores s_data in lane k,
//         bits [8k+7:8k]. Then k increments and the remaining count decrements.
//       - Go to WRITE in the cycle after the handshake that fills lane 7 or consumes
//         the last byte.
//       - Unfilled lanes of a short final word are 0.
//   - WRITE (exactly 1 cycle):
//       - s_ready=0, buf_write_en=1, buf_addr_mode=1.
//       - buf_word_addr = current address; buf_word_in = packed word.
//       - At exit: address += 1, wrapping mod BuffDepth/8; k=0; pack register cleared.
//       - Next state is DONE if remaining==0, else FILL.
//   - DONE: done=1 for one cycle, busy=0, then IDLE.
//   - start is ignored while busy or in DONE.
//   - Latency:
//       - Byte 8 accepted in cycle n -> write strobe in cycle n+1 -> done in cycle n+2
//         (if last).
//       - Sustained throughput: 8 bytes per 9 cycles.
//   - num_bytes > BuffDepth: clamp to BuffDepth.
//   - Address wrap past the top word is legal and silent.
//   - buf_word_addr/buf_word_in hold their last values outside WRITE; only
//     buf_write_en qualifies them.
// TESTING
//   1. base=3, n=8, bytes 11..88 back-to-back:
//      - one write: addr 3, data 64'h8877665544332211.
//      - s_ready=0 during the write cycle; done 1 cycle after the write.
//   2. base=0, n=11, bytes 01..0B:
//      - word0 = 64'h0807060504030201.
//      - word1 = 64'h00000000000B0A09.
//      - exactly 2 strobes, then done.
//   3. base=15, n=16: writes go to word 15 then word 0 (wrap); done after the second.
//   4. n=0: done pulses 1 cycle after start; buf_write_en never asserts; busy stays 0.
//   5. s_valid toggled randomly, plus start pulsed while busy:
//      - data is identical to test 1.
//      - the second start has no effect.
//   6. rst_n=0 after 5 bytes accepted:
//      - all outputs 0 immediately; no write issued.
//      - a new transfer after release completes correctly.

Source files
------------

// File: rtl/buffer_loader.sv
// Byte-stream to 64-bit word packer feeding the scratch buffer in word mode.
// Each command packs num_bytes little-endian bytes into words at incrementing addresses.
module buffer_loader #(
  parameter  int BuffDepth = 128,
  localparam int ByteAddrW = $clog2(BuffDepth),
  localparam int WordAddrW = $clog2(BuffDepth / 8)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WordAddrW-1:0] base_addr,
  input  logic [ByteAddrW:0]   num_bytes,
  output logic                 busy,
  output logic                 done,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  output logic                 buf_write_en,
  output logic                 buf_addr_mode,
  output logic [WordAddrW-1:0] buf_word_addr,
  output logic [63:0]          buf_word_in
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  localparam logic [ByteAddrW:0]   MaxBytes = (ByteAddrW + 1)'(BuffDepth);
  localparam logic [WordAddrW-1:0] TopWord  = WordAddrW'(BuffDepth / 8 - 1);

  state_t               state, next_state;
  logic [WordAddrW-1:0] addr_q;
  logic [ByteAddrW:0]   remaining;
  logic [2:0]           lane;
  logic [63:0]          pack;
  logic [WordAddrW-1:0] hold_addr;
  logic [63:0]          hold_word;
  logic [ByteAddrW:0]   clamped;
  logic                 hs;

  assign clamped = (num_bytes > MaxBytes) ? MaxBytes : num_bytes;
  assign hs      = (state == FILL) && s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = (clamped == '0) ? DONE : FILL;
      FILL:  if (hs && (lane == 3'd7 || remaining == (ByteAddrW + 1)'(1))) next_state = WRITE;
      WRITE: next_state = (remaining == '0) ? DONE : FILL;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: command latch, byte lane packing, and post-write address/pack turnover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
      lane      <= '0;
      pack      <= '0;
      hold_addr <= '0;
      hold_word <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_q    <= base_addr;
          remaining <= clamped;
          lane      <= '0;
          pack      <= '0;
        end
        FILL: if (hs) begin
          pack[{lane, 3'b000} +: 8] <= s_data;
          lane      <= lane + 3'd1;
          remaining <= remaining - (ByteAddrW + 1)'(1);
        end
        WRITE: begin
          hold_addr <= addr_q;
          hold_word <= pack;
          addr_q    <= (addr_q == TopWord) ? '0 : addr_q + WordAddrW'(1);
          lane      <= '0;
          pack      <= '0;
        end
        default: ;
      endcase
    end
  end

  // Word address/data show the live values while writing and hold the last written pair otherwise.
  always_comb begin
    busy          = (state == FILL) || (state == WRITE);
    done          = (state == DONE);
    s_ready       = (state == FILL);
    buf_write_en  = (state == WRITE);
    buf_addr_mode = (state == WRITE);
    buf_word_addr = (state == WRITE) ? addr_q : hold_addr;
    buf_word_in   = (state == WRITE) ? pack   : hold_word;
  end

endmodule

// File: tb/tb_buffer_loader.sv
// Directed bench for buffer_loader: table of transfers with hand-computed words,
// plus hand-written reset-in-the-middle and initial reset sequences.
module tb_buffer_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [7:0]  num_bytes;
  logic        busy, done, s_valid, s_ready;
  logic [7:0]  s_data;
  logic        buf_write_en, buf_addr_mode;
  logic [3:0]  buf_word_addr;
  logic [63:0] buf_word_in;

  buffer_loader #(.BuffDepth(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .buf_write_en(buf_write_en), .buf_addr_mode(buf_addr_mode),
    .buf_word_addr(buf_word_addr), .buf_word_in(buf_word_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  base;
    logic [7:0]  n;
    logic [7:0]  b0;
    logic [7:0]  step;
    bit          rnd;
    bit          poke;
    int          nwr;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [63:0] w0;
    logic [63:0] w1;
  } vec_t;

  vec_t vecs[6];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [3:0]  wr_addr[$];
  logic [63:0] wr_data[$];
  int          wr_cyc[$];
  int          wr_bad;
  int          done_cnt;
  int          done_cyc;
  bit          busy_seen;
  int          last_hs;
  int          start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (buf_write_en) begin
      wr_addr.push_back(buf_word_addr);
      wr_data.push_back(buf_word_in);
      wr_cyc.push_back(cyc);
      if (s_ready || !buf_addr_mode) wr_bad = wr_bad + 1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearMonitor();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wr_bad    = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    busy_seen = 1'b0;
    last_hs   = -1;
  endtask

  task automatic issueStart(input logic [3:0] b, input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_bytes = n; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feedBytes(input vec_t v, input int count);
    int i;
    int guard;
    bit hs;
    i = 0;
    guard = 0;
    while (i < count && guard < 3000) begin
      s_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = v.b0 + 8'(i) * v.step;
      if (v.poke && i == 3) begin
        start = 1'b1; base_addr = 4'd9; num_bytes = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) last_hs = cyc;
      @(posedge clk); #1;
      if (hs) i = i + 1;
      guard = guard + 1;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    if (guard >= 3000) checkVal("feed_timeout", 64'(i), 64'(count));
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (done_cnt == 0 && k < 60) begin
      @(posedge clk); #1;
      k = k + 1;
    end
    if (done_cnt == 0) checkVal("done_timeout", 64'(0), 64'(1));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    int eff;
    eff = (v.n > 8'd128) ? 128 : int'(v.n);
    clearMonitor();
    issueStart(v.base, v.n);
    feedBytes(v, eff);
    waitDone();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    int last;
    checkVal($sformatf("v%0d_writes", idx), 64'(wr_addr.size()), 64'(v.nwr));
    checkVal($sformatf("v%0d_done_cnt", idx), 64'(done_cnt), 64'(1));
    checkVal($sformatf("v%0d_busy_seen", idx), 64'(busy_seen), 64'(v.n != 8'd0));
    checkVal($sformatf("v%0d_strobe_ctl", idx), 64'(wr_bad), 64'(0));
    if (v.nwr >= 1 && wr_addr.size() >= 1) begin
      last = wr_cyc.size() - 1;
      checkVal($sformatf("v%0d_addr0", idx), 64'(wr_addr[0]), 64'(v.a0));
      checkVal($sformatf("v%0d_word0", idx), wr_data[0], v.w0);
      checkVal($sformatf("v%0d_wr_latency", idx), 64'(wr_cyc[last]), 64'(last_hs + 1));
      checkVal($sformatf("v%0d_done_latency", idx), 64'(done_cyc), 64'(wr_cyc[last] + 1));
    end
    if (v.nwr >= 2 && wr_addr.size() >= 2) begin
      checkVal($sformatf("v%0d_addr1", idx), 64'(wr_addr[1]), 64'(v.a1));
      checkVal($sformatf("v%0d_word1", idx), wr_data[1], v.w1);
    end
    if (v.nwr == 0) checkVal($sformatf("v%0d_done_after_start", idx), 64'(done_cyc), 64'(start_cyc + 1));
  endtask

  initial begin
    vecs[0] = '{4'd3,  8'd8,   8'h11, 8'h11, 1'b0, 1'b0, 1,  4'd3,  4'd0, 64'h8877665544332211, 64'h0};
    vecs[1] = '{4'd0,  8'd11,  8'h01, 8'h01, 1'b0, 1'b0, 2,  4'd0,  4'd1, 64'h0807060504030201, 64'h00000000000B0A09};
    vecs[2] = '{4'd15, 8'd16,  8'hA0, 8'h01, 1'b0, 1'b0, 2,  4'd15, 4'd0, 64'hA7A6A5A4A3A2A1A0, 64'hAFAEADACABAAA9A8};
    vecs[3] = '{4'd7,  8'd0,   8'h00, 8'h00, 1'b0, 1'b0, 0,  4'd0,  4'd0, 64'h0, 64'h0};
    vecs[4] = '{4'd3,  8'd8,   8'h11, 8'h11, 1'b1, 1'b1, 1,  4'd3,  4'd0, 64'h8877665544332211, 64'h0};
    vecs[5] = '{4'd0,  8'd200, 8'h00, 8'h01, 1'b0, 1'b0, 16, 4'd0,  4'd1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_bytes = '0; s_valid = 1'b0; s_data = '0;
    clearMonitor();
    #3;
    checkVal("rst_outputs", {busy, done, s_ready, buf_write_en, buf_addr_mode, buf_word_addr, buf_word_in},
             '0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d: base=%0d n=%0d", i, vecs[i].base, vecs[i].n);
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Reset arriving after five accepted bytes must drop the partial word.
    $display("[TB] reset mid-transfer");
    clearMonitor();
    issueStart(4'd2, 8'd16);
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(i + 1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkVal("midrst_outputs", {busy, done, s_ready, buf_write_en, buf_addr_mode, buf_word_addr, buf_word_in},
             '0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    checkVal("midrst_no_write", 64'(wr_addr.size()), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(vecs[0]);
    checkOutput(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
